// File: rtl/obstacle_pool_control.sv
// obstacle_pool_control: pool of NUM_OBS obstacle slots flying an arc
// trajectory leftwards. A shared scheduler launches a new obstacle into the
// lowest free slot every SPAWN_GAP ticks. Each launch height is randomised
// from a 16-bit LFSR. All motion advances on game_en. clear_all retires the
// whole pool.
module obstacle_pool_control #(
    parameter int          NUM_OBS      = 4,
    parameter int          OBS_WIDTH    = 30,
    parameter int          OBS_HEIGHT   = 30,
    parameter int          X_SPEED      = 5,
    parameter int          X_START      = 640,
    parameter int          Y_BASELINE   = 315,
    parameter int          Y_OFFSET_MIN = 100,
    parameter logic [9:0]  Y_RAND_MASK  = 10'h03F,
    parameter int          Y_AMPLITUDE  = 10,
    parameter int          Y_STEP       = 3,
    parameter int          SPAWN_GAP    = 40,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   game_en,
    input  logic                   spawn_en,
    input  logic                   clear_all,
    input  logic [1:0]             speed_sel,
    input  logic [NUM_OBS-1:0]     collision,
    output logic [NUM_OBS-1:0]     obs_active,
    output logic [10*NUM_OBS-1:0]  obs_x_pos,
    output logic [10*NUM_OBS-1:0]  obs_y_pos,
    output logic [9:0]             obs_width,
    output logic [9:0]             obs_height,
    output logic [15:0]            spawn_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASCEND  = 2'd1,
        ST_DESCEND = 2'd2
    } slot_state_t;

    localparam logic [9:0]  X_START_V = 10'(X_START);
    localparam logic [9:0]  Y_REST    = 10'(Y_BASELINE - OBS_HEIGHT);
    localparam logic [9:0]  Y_STEP_V  = 10'(Y_STEP);
    localparam logic [9:0]  Y_AMP_V   = 10'(Y_AMPLITUDE);
    localparam logic [9:0]  Y_MIN_V   = 10'(Y_OFFSET_MIN);
    localparam logic [15:0] GAP_V     = 16'(SPAWN_GAP);

    // Per-slot state; state_q doubles as the visible FSM state for debug.
    slot_state_t state_q  [NUM_OBS];
    logic        active_q [NUM_OBS];
    logic [9:0]  x_q      [NUM_OBS];
    logic [9:0]  y_q      [NUM_OBS];
    logic [9:0]  off_q    [NUM_OBS];
    logic [9:0]  launch_q [NUM_OBS];

    logic [15:0]        gap_q;
    logic [15:0]        lfsr_q;
    logic [15:0]        count_q;
    logic [9:0]         speed;
    logic [9:0]         launch_new;
    logic               lfsr_fb;
    logic [NUM_OBS-1:0] spawn_sel;
    logic               slot_free;
    logic               spawn_fire;

    // Effective speed, launch height from the pre-advance LFSR, and feedback.
    always_comb begin
        speed      = 10'(X_SPEED) + 10'(speed_sel);
        launch_new = Y_MIN_V + (lfsr_q[9:0] & Y_RAND_MASK);
        lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    end

    // Lowest-index slot that is idle at the start of the tick; a slot that
    // retires this tick is still in flight here and so is never picked.
    always_comb begin
        spawn_sel = '0;
        slot_free = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (!slot_free && state_q[i] == ST_IDLE) begin
                spawn_sel[i] = 1'b1;
                slot_free    = 1'b1;
            end
        end
        spawn_fire = (gap_q == 16'd0) && spawn_en && slot_free;
    end

    // Slot FSMs, spawn scheduler, LFSR and spawn counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                state_q[i]  <= ST_IDLE;
                active_q[i] <= 1'b0;
                x_q[i]      <= X_START_V;
                y_q[i]      <= Y_REST;
                off_q[i]    <= 10'd0;
                launch_q[i] <= 10'd0;
            end
            gap_q   <= GAP_V;
            lfsr_q  <= LFSR_SEED;
            count_q <= 16'd0;
        end else if (clear_all) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                state_q[i]  <= ST_IDLE;
                active_q[i] <= 1'b0;
                x_q[i]      <= X_START_V;
                y_q[i]      <= Y_REST;
                off_q[i]    <= 10'd0;
            end
            gap_q <= GAP_V;
        end else if (game_en) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                if (state_q[i] != ST_IDLE) begin
                    if (collision[i] || (x_q[i] <= speed) ||
                        (state_q[i] == ST_DESCEND && off_q[i] <= Y_STEP_V)) begin
                        state_q[i]  <= ST_IDLE;
                        active_q[i] <= 1'b0;
                        x_q[i]      <= X_START_V;
                        y_q[i]      <= Y_REST;
                        off_q[i]    <= 10'd0;
                    end else if (state_q[i] == ST_ASCEND) begin
                        x_q[i] <= x_q[i] - speed;
                        if (off_q[i] >= launch_q[i] + Y_AMP_V) begin
                            state_q[i] <= ST_DESCEND;
                        end else begin
                            off_q[i] <= off_q[i] + Y_STEP_V;
                            y_q[i]   <= Y_REST - (off_q[i] + Y_STEP_V);
                        end
                    end else begin
                        x_q[i]   <= x_q[i] - speed;
                        off_q[i] <= off_q[i] - Y_STEP_V;
                        y_q[i]   <= Y_REST - (off_q[i] - Y_STEP_V);
                    end
                end else if (spawn_sel[i] && spawn_fire) begin
                    state_q[i]  <= ST_ASCEND;
                    active_q[i] <= 1'b1;
                    x_q[i]      <= X_START_V;
                    off_q[i]    <= launch_new;
                    launch_q[i] <= launch_new;
                    y_q[i]      <= Y_REST - launch_new;
                end
            end
            if (gap_q != 16'd0) begin
                gap_q <= gap_q - 16'd1;
            end else if (spawn_fire) begin
                gap_q <= GAP_V;
                if (count_q != 16'hFFFF) begin
                    count_q <= count_q + 16'd1;
                end
            end
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    // Pack the per-slot registers onto the flat output buses.
    always_comb begin
        obs_active = '0;
        obs_x_pos  = '0;
        obs_y_pos  = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            obs_active[i]        = active_q[i];
            obs_x_pos[10*i +: 10] = x_q[i];
            obs_y_pos[10*i +: 10] = y_q[i];
        end
        obs_width   = 10'(OBS_WIDTH);
        obs_height  = 10'(OBS_HEIGHT);
        spawn_count = count_q;
    end

endmodule

// File: tb/tb_obstacle_pool_control.sv
// tb_obstacle_pool_control: three pool configurations share the control
// inputs. A behavioural model of the game rules predicts every slot each tick.
module tb_obstacle_pool_control;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       game_en, spawn_en, clear_all;
    logic [1:0] spd_a, spd_b, spd_c;
    logic [3:0] coll_a;
    logic [1:0] coll_b;
    logic [0:0] coll_c;

    logic [3:0]  act_a;  logic [39:0] xa, ya;  logic [9:0] wa, ha;  logic [15:0] cnt_a;
    logic [1:0]  act_b;  logic [19:0] xb, yb;  logic [9:0] wb, hb;  logic [15:0] cnt_b;
    logic [0:0]  act_c;  logic [9:0]  xc, yc;  logic [9:0] wc, hc;  logic [15:0] cnt_c;

    obstacle_pool_control #(.NUM_OBS(4), .Y_RAND_MASK(10'h000)) dut_a (
        .clk(clk), .rst(rst), .game_en(game_en), .spawn_en(spawn_en),
        .clear_all(clear_all), .speed_sel(spd_a), .collision(coll_a),
        .obs_active(act_a), .obs_x_pos(xa), .obs_y_pos(ya),
        .obs_width(wa), .obs_height(ha), .spawn_count(cnt_a));

    obstacle_pool_control #(.NUM_OBS(2), .SPAWN_GAP(5), .Y_RAND_MASK(10'h03F)) dut_b (
        .clk(clk), .rst(rst), .game_en(game_en), .spawn_en(spawn_en),
        .clear_all(clear_all), .speed_sel(spd_b), .collision(coll_b),
        .obs_active(act_b), .obs_x_pos(xb), .obs_y_pos(yb),
        .obs_width(wb), .obs_height(hb), .spawn_count(cnt_b));

    obstacle_pool_control #(.NUM_OBS(1), .SPAWN_GAP(2), .X_START(40),
                            .Y_RAND_MASK(10'h000)) dut_c (
        .clk(clk), .rst(rst), .game_en(game_en), .spawn_en(spawn_en),
        .clear_all(clear_all), .speed_sel(spd_c), .collision(coll_c),
        .obs_active(act_c), .obs_x_pos(xc), .obs_y_pos(yc),
        .obs_width(wc), .obs_height(hc), .spawn_count(cnt_c));

    // ---------------- reference model ----------------
    int cfg_num  [3] = '{4, 2, 1};
    int cfg_gap  [3] = '{40, 5, 2};
    int cfg_xs   [3] = '{640, 640, 40};
    int cfg_mask [3] = '{0, 63, 0};

    bit          m_act    [3][8];
    bit          m_desc   [3][8];
    int          m_x      [3][8];
    int          m_off    [3][8];
    int          m_launch [3][8];
    int          m_gap    [3];
    logic [15:0] m_lfsr   [3];
    int          m_cnt    [3];

    int n_checks = 0;
    int n_errors = 0;

    task automatic model_retire(input int k, input int i);
        m_act[k][i]  = 1'b0;
        m_desc[k][i] = 1'b0;
        m_x[k][i]    = cfg_xs[k];
        m_off[k][i]  = 0;
    endtask

    task automatic model_reset(input int k);
        for (int i = 0; i < 8; i++) begin
            model_retire(k, i);
            m_launch[k][i] = 0;
        end
        m_gap[k]  = cfg_gap[k];
        m_lfsr[k] = 16'hACE1;
        m_cnt[k]  = 0;
    endtask

    task automatic model_step(input int k, input logic ge, input logic se, input logic ca,
                              input logic [1:0] sp, input logic [7:0] co);
        bit idle0 [8];
        int speed_v;
        int pick;
        logic fb;
        if (ca) begin
            for (int i = 0; i < 8; i++) model_retire(k, i);
            m_gap[k] = cfg_gap[k];
            return;
        end
        if (!ge) return;
        speed_v = 5 + int'(sp);
        for (int i = 0; i < 8; i++) idle0[i] = !m_act[k][i];
        for (int i = 0; i < cfg_num[k]; i++) begin
            if (m_act[k][i]) begin
                if (co[i] || m_x[k][i] <= speed_v || (m_desc[k][i] && m_off[k][i] <= 3)) begin
                    model_retire(k, i);
                end else begin
                    m_x[k][i] = m_x[k][i] - speed_v;
                    if (m_desc[k][i]) m_off[k][i] = m_off[k][i] - 3;
                    else if (m_off[k][i] >= m_launch[k][i] + 10) m_desc[k][i] = 1'b1;
                    else m_off[k][i] = m_off[k][i] + 3;
                end
            end
        end
        if (m_gap[k] != 0) begin
            m_gap[k] = m_gap[k] - 1;
        end else if (se) begin
            pick = -1;
            for (int i = 0; i < cfg_num[k]; i++)
                if (pick < 0 && idle0[i]) pick = i;
            if (pick >= 0) begin
                m_act[k][pick]    = 1'b1;
                m_desc[k][pick]   = 1'b0;
                m_x[k][pick]      = cfg_xs[k];
                m_launch[k][pick] = 100 + (int'(m_lfsr[k][9:0]) & cfg_mask[k]);
                m_off[k][pick]    = m_launch[k][pick];
                m_gap[k]          = cfg_gap[k];
                if (m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
            end
        end
        // Taps 16,14,13,11 counted from 1 are bits 15,13,12,10.
        fb = m_lfsr[k][15] ^ m_lfsr[k][13] ^ m_lfsr[k][12] ^ m_lfsr[k][10];
        m_lfsr[k] = {m_lfsr[k][14:0], fb};
    endtask

    function automatic logic [63:0] exp_act(input int k);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < cfg_num[k]; i++) r[i] = m_act[k][i];
        return r;
    endfunction

    function automatic logic [63:0] exp_x(input int k);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < cfg_num[k]; i++) r[10*i +: 10] = 10'(m_x[k][i]);
        return r;
    endfunction

    function automatic logic [63:0] exp_y(input int k);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < cfg_num[k]; i++) r[10*i +: 10] = 10'(285 - m_off[k][i]);
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("a_act", 64'(act_a), exp_act(0));
        check_eq("a_x",   64'(xa),    exp_x(0));
        check_eq("a_y",   64'(ya),    exp_y(0));
        check_eq("a_cnt", 64'(cnt_a), 64'(m_cnt[0]));
        check_eq("b_act", 64'(act_b), exp_act(1));
        check_eq("b_x",   64'(xb),    exp_x(1));
        check_eq("b_y",   64'(yb),    exp_y(1));
        check_eq("b_cnt", 64'(cnt_b), 64'(m_cnt[1]));
        check_eq("c_act", 64'(act_c), exp_act(2));
        check_eq("c_x",   64'(xc),    exp_x(2));
        check_eq("c_y",   64'(yc),    exp_y(2));
        check_eq("c_cnt", 64'(cnt_c), 64'(m_cnt[2]));
    endtask

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_step(0, game_en, spawn_en, clear_all, spd_a, {4'b0, coll_a});
            model_step(1, game_en, spawn_en, clear_all, spd_b, {6'b0, coll_b});
            model_step(2, game_en, spawn_en, clear_all, spd_c, {7'b0, coll_c});
        end
        #1;
        compare_all();
    endtask

    task automatic reset_all_models();
        for (int k = 0; k < 3; k++) model_reset(k);
    endtask

    initial begin
        rst = 1'b0; game_en = 1'b0; spawn_en = 1'b1; clear_all = 1'b0;
        spd_a = 2'd0; spd_b = 2'd0; spd_c = 2'd3;
        coll_a = '0; coll_b = '0; coll_c = '0;
        reset_all_models();
        #12;
        check_eq("rst_act",   64'(act_a), 64'd0);
        check_eq("rst_x",     64'(xa),    64'({4{10'd640}}));
        check_eq("rst_y",     64'(ya),    64'({4{10'd285}}));
        check_eq("rst_cnt",   64'(cnt_a), 64'd0);
        check_eq("width",     64'(wa),    64'd30);
        check_eq("height",    64'(ha),    64'd30);
        compare_all();
        @(negedge clk);
        rst = 1'b1;
        game_en = 1'b1;

        // Directed arc, underflow guard and pool-full stall.
        for (int t = 1; t <= 100; t++) begin
            step();
            if (t == 40) check_eq("a_nospawn_t40", 64'(act_a), 64'd0);
            if (t == 41) begin
                check_eq("a_spawn_act", 64'(act_a[0]), 64'd1);
                check_eq("a_spawn_x",   64'(xa[9:0]),  64'd640);
                check_eq("a_spawn_y",   64'(ya[9:0]),  64'd185);
                check_eq("a_spawn_cnt", 64'(cnt_a),    64'd1);
            end
            if (t == 45) begin
                check_eq("a_t4_x", 64'(xa[9:0]), 64'd620);
                check_eq("a_t4_y", 64'(ya[9:0]), 64'd173);
            end
            if (t == 46) begin
                check_eq("a_t5_x", 64'(xa[9:0]), 64'd615);
                check_eq("a_t5_y", 64'(ya[9:0]), 64'd173);
            end
            if (t == 83) begin
                check_eq("a_t42_x", 64'(xa[9:0]), 64'd430);
                check_eq("a_t42_y", 64'(ya[9:0]), 64'd284);
            end
            if (t == 84) begin
                check_eq("a_t43_act", 64'(act_a[0]), 64'd0);
                check_eq("a_t43_x",   64'(xa[9:0]),  64'd640);
                check_eq("a_t43_y",   64'(ya[9:0]),  64'd285);
            end
            if (t == 7) check_eq("c_x_at8", 64'(xc), 64'd8);
            if (t == 8) begin
                check_eq("c_retire_act", 64'(act_c), 64'd0);
                check_eq("c_retire_x",   64'(xc),    64'd40);
            end
            if (t == 9) check_eq("c_respawn", 64'(act_c), 64'd1);
            if (t == 20) begin
                check_eq("b_full_act", 64'(act_b), 64'd3);
                check_eq("b_full_cnt", 64'(cnt_b), 64'd2);
            end
        end

        // clear_all while slots are in flight, then the gap restarts at 40.
        clear_all = 1'b1;
        step();
        clear_all = 1'b0;
        check_eq("clr_act_a", 64'(act_a), 64'd0);
        check_eq("clr_act_b", 64'(act_b), 64'd0);
        for (int t = 1; t <= 41; t++) begin
            step();
            if (t == 40) check_eq("clr_gap_hold", 64'(act_a), 64'd0);
            if (t == 41) check_eq("clr_gap_fire", 64'(act_a), 64'd1);
        end
        for (int t = 0; t < 5; t++) step();

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b0;
        #1;
        reset_all_models();
        check_eq("arst_act", 64'(act_a), 64'd0);
        check_eq("arst_x",   64'(xa),    64'({4{10'd640}}));
        check_eq("arst_y",   64'(ya),    64'({4{10'd285}}));
        check_eq("arst_cnt", 64'(cnt_b), 64'd0);
        compare_all();
        @(negedge clk);
        rst = 1'b1;

        // Randomised traffic.
        for (int t = 0; t < 3000; t++) begin
            game_en   = ($urandom_range(0, 3) != 0);
            spawn_en  = ($urandom_range(0, 9) != 0);
            clear_all = ($urandom_range(0, 199) == 0);
            spd_a     = 2'($urandom_range(0, 3));
            spd_b     = 2'($urandom_range(0, 3));
            spd_c     = 2'($urandom_range(0, 3));
            coll_a    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            coll_b    = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b0;
            coll_c    = ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/obstacle_pool_control.md
Name: obstacle_pool_control

Overview:
- Parametrised multi-slot obstacle generator; successor to the single-obstacle arc controller.
- Manages NUM_OBS independent obstacle slots, each with its own arc trajectory and retire logic.
- A shared spawn scheduler with a gap counter and LFSR-randomised launch height feeds the slots.
- Sits between the game clock generator and the renderer/collision detector.

Parameters:
NUM_OBS, 4, number of obstacle slots (1..8)
OBS_WIDTH, 30, obstacle width in pixels
OBS_HEIGHT, 30, obstacle height in pixels
X_SPEED, 5, base leftward pixels per tick
X_START, 640, spawn x (off-screen right)
Y_BASELINE, 315, ground line; rest y_pos = Y_BASELINE-OBS_HEIGHT
Y_OFFSET_MIN, 100, minimum launch height above rest
Y_RAND_MASK, 10'h03F, mask on LFSR bits added to launch height; 0 = deterministic
Y_AMPLITUDE, 10, extra rise above launch height before falling
Y_STEP, 3, vertical pixels per tick
SPAWN_GAP, 40, ticks between spawns
LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-low reset
game_en  in  1  one-cycle tick enable; all motion advances only on game_en
spawn_en  in  1  permits new spawns (gap counter still runs)
clear_all  in  1  synchronous retire of all slots, independent of game_en
speed_sel  in  2  added to X_SPEED; effective speed = X_SPEED+speed_sel
collision  in  NUM_OBS  per-slot collision, sampled on game_en
obs_active  out  NUM_OBS  slot in flight
obs_x_pos  out  10*NUM_OBS  slot i at [10i+9:10i]
obs_y_pos  out  10*NUM_OBS  top edge, same packing
obs_width  out  10  constant OBS_WIDTH
obs_height  out  10  constant OBS_HEIGHT
spawn_count  out  16  total spawns since reset, saturating at 16'hFFFF

Behaviour:
- Reset: every slot IDLE, obs_active=0, x=X_START, y=Y_BASELINE-OBS_HEIGHT, y_offset=0. gap_cnt=SPAWN_GAP, lfsr=LFSR_SEED, spawn_count=0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances once per game_en.
- Per-slot FSM: IDLE, ASCEND, DESCEND. All transitions occur on game_en only, except clear_all.
- Retire, checked first each tick, applies in ASCEND or DESCEND. Triggered by any of:
  - collision[i]=1,
  - x <= effective speed (no wrap below 0),
  - state DESCEND and y_offset <= Y_STEP.
  Retire sets IDLE, active=0, x=X_START, y=rest.
- ASCEND (not retiring):
  - x -= speed.
  - If y_offset >= launch+Y_AMPLITUDE: go to DESCEND, y_offset unchanged.
  - Otherwise y_offset += Y_STEP.
- DESCEND (not retiring): x -= speed, y_offset -= Y_STEP.
- y_pos = Y_BASELINE-OBS_HEIGHT-y_offset, computed from the NEW y_offset in the same tick (no one-tick lag).
- launch (latched per slot at spawn) = Y_OFFSET_MIN + (lfsr[9:0] & Y_RAND_MASK), using the pre-advance lfsr.
- Spawn scheduler, per game_en:
  - If gap_cnt != 0: gap_cnt decrements.
  - If gap_cnt == 0, spawn_en=1 and at least one slot was IDLE at tick start: the lowest-index IDLE slot spawns. That slot gets state ASCEND, active=1, x=X_START, y_offset=launch, y=rest-launch. gap_cnt reloads SPAWN_GAP and spawn_count increments.
  - If no slot is free or spawn_en=0: gap_cnt holds at 0 and the spawn fires on the first eligible tick.
- A slot that retires in a tick is not eligible to spawn in that same tick.
- clear_all: retires all slots and reloads gap_cnt=SPAWN_GAP. It overrides game_en activity in the same cycle. The lfsr and spawn_count are not reset.
- Parameter constraints: Y_OFFSET_MIN + Y_RAND_MASK + Y_AMPLITUDE + Y_STEP <= Y_BASELINE-OBS_HEIGHT; X_START <= 1023.
- Asynchronous reset mid-flight: immediately returns every output to its reset value.
- Outputs are registered; game_en held low freezes all state.

Test Plan:
- Setup for all scenarios: defaults with Y_RAND_MASK=0, speed_sel=0.
- Reset -> active=0000, every x=640, every y=285, spawn_count=0. After 40 game_en ticks still no spawn. Tick 41: slot0 active, x=640, y=185.
- Slot0 arc, spawn tick = T0:
  - T4: x=620, y=173 (offset 112).
  - T5: offset 112 held, state DESCEND.
  - T42: offset 1, x=430.
  - T43: slot0 retires, active[0]=0, x=640, y=285.
- Collision: assert collision[0] at T10 -> slot0 retires that tick. Slot1 still spawns on its own gap schedule; lowest free index is reused on the next spawn.
- Pool full: NUM_OBS=2, SPAWN_GAP=5 -> third spawn stalls with gap_cnt=0. It fires on the tick after the first retire, into the freed slot; spawn_count=3.
- speed_sel=3, X_START=40 -> x goes 40,32,24,16,8; slot retires on the tick x=8 (<=8), with no underflow to 1016.
- clear_all mid-flight with 3 active -> next cycle active=0000, gap reloaded to 40. Async rst pulse mid-arc -> immediate reset values.
